// File: rtl/adc_boxcar_decimator.sv
// Boxcar decimator for the raw ADC stream: averages blocks of 2^dec_log2 signed
// samples and presents each average on an AXI-Stream output with a one-word holding register.
module adc_boxcar_decimator #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DEC_LOG2_MAX     = 10,
  parameter int OVR_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [3:0]                  dec_log2,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN_tdata,
  input  logic                        S_AXIS_IN_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic [OVR_WIDTH-1:0]        overrun_count,
  output logic                        busy,
  output logic                        state_dbg
);

  // Handshake: a word transfers on any rising clk edge where M_AXIS_OUT_tvalid and
  // M_AXIS_OUT_tready are both 1; once raised, tvalid and tdata hold until that edge
  // unless a newer result replaces the word. The input has no tready: every beat
  // with S_AXIS_IN_tvalid=1 is taken.

  localparam int ACC_W = ADC_WIDTH + DEC_LOG2_MAX;
  localparam int CNT_W = DEC_LOG2_MAX;
  localparam logic [3:0] SHIFT_MAX = 4'(DEC_LOG2_MAX);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [3:0]                    shift_q, shift_d;
  logic [AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
  logic                          valid_q, valid_d;
  logic [OVR_WIDTH-1:0]          ovr_q, ovr_d;

  logic [3:0]                    shift_clamped;
  logic signed [ADC_WIDTH-1:0]   sample;
  logic signed [ACC_W-1:0]       sample_ext;
  logic signed [ACC_W-1:0]       sum;
  logic signed [ACC_W-1:0]       result;
  logic [CNT_W-1:0]              block_max;
  logic                          last_beat;
  logic                          new_result;

  always_comb begin
    shift_clamped = (dec_log2 > SHIFT_MAX) ? SHIFT_MAX : dec_log2;
    sample        = S_AXIS_IN_tdata[ADC_WIDTH-1:0];
    sample_ext    = {{DEC_LOG2_MAX{sample[ADC_WIDTH-1]}}, sample};
    sum           = acc_q + sample_ext;
    // Arithmetic shift floors toward minus infinity, which is the intended rounding.
    result        = sum >>> shift_q;
    block_max     = CNT_W'((32'd1 << shift_q) - 32'd1);
    last_beat     = (cnt_q == block_max);
  end

  // Next-state and datapath decisions for the block accumulator.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    new_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          shift_d = shift_clamped;
        end
      end
      ACCUM: begin
        if (!en) begin
          // Partial block is dropped without producing a word.
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (S_AXIS_IN_tvalid) begin
          if (last_beat) begin
            new_result = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            shift_d    = shift_clamped;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register; a new result always wins over the pending word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (new_result) begin
      data_d  = {{(AXIS_TDATA_WIDTH-ACC_W){result[ACC_W-1]}}, result};
      valid_d = 1'b1;
      if (valid_q && !M_AXIS_OUT_tready && (ovr_q != '1)) begin
        ovr_d = ovr_q + OVR_WIDTH'(1);
      end
    end else if (valid_q && M_AXIS_OUT_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign M_AXIS_OUT_tdata  = data_q;
  assign M_AXIS_OUT_tvalid = valid_q;
  assign overrun_count     = ovr_q;
  assign busy              = (state_q == ACCUM) && (cnt_q != '0);
  assign state_dbg         = state_q;

endmodule

// File: doc/adc_boxcar_decimator.md
Name: adc_boxcar_decimator

Overview:
Front-end stage that directly feeds the Kalman filter block. It takes the raw 125 MHz ADC AXI-Stream, extracts the signed 14-bit sample, and averages blocks of 2^dec_log2 consecutive accepted samples. Each block average is emitted as one decimated AXI-Stream word. Output backpressure is handled with a single holding register, and overruns are counted.

Parameters:
ADC_WIDTH, 14, signed sample width taken from tdata[ADC_WIDTH-1:0]
AXIS_TDATA_WIDTH, 32, input and output tdata width
DEC_LOG2_MAX, 10, largest decimation exponent (1024 samples per block)
OVR_WIDTH, 16, overrun counter width

Ports:
clk  input  1  system clock, 125 MHz
rst  input  1  asynchronous, active-low reset
en  input  1  1 = accumulate; 0 = idle, partial block discarded
dec_log2  input  4  decimation exponent; values above DEC_LOG2_MAX are clamped to DEC_LOG2_MAX
S_AXIS_IN_tdata  input  AXIS_TDATA_WIDTH  ADC word; only bits [ADC_WIDTH-1:0] are used, signed
S_AXIS_IN_tvalid  input  1  input beat valid; there is no tready, every valid beat is accepted
M_AXIS_OUT_tdata  output  AXIS_TDATA_WIDTH  block average, sign-extended
M_AXIS_OUT_tvalid  output  1  output word valid
M_AXIS_OUT_tready  input  1  downstream ready
overrun_count  output  OVR_WIDTH  number of results overwritten while unaccepted; saturates at all-ones
busy  output  1  high while a partial block is held (state ACCUM with cnt != 0)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc, cnt, M_AXIS_OUT_tdata, M_AXIS_OUT_tvalid, overrun_count and busy all 0. Any partial block is lost. Registers release on the first clk edge after rst=1.
- FSM states: IDLE, ACCUM.
  - IDLE -> ACCUM when en=1. On entry: acc=0, cnt=0, shift_l = clamp(dec_log2).
  - ACCUM -> IDLE when en=0. acc and cnt are cleared; no output is produced for the partial block.
- Accumulator: signed, ADC_WIDTH+DEC_LOG2_MAX bits (24). It cannot overflow for any legal shift.
- Input beat in ACCUM with tvalid=1, not last of block: acc += sample; cnt += 1.
- Last beat of block (cnt == 2^shift_l - 1, tvalid=1), all in the same edge:
  - result = (acc + sample) >>> shift_l: arithmetic shift, rounding toward minus infinity.
  - result is loaded into the output register, sign-extended to AXIS_TDATA_WIDTH.
  - acc=0, cnt=0.
  - shift_l is reloaded from clamp(dec_log2).
- dec_log2 changes mid-block take effect only at the next block boundary.
- shift_l=0 is pass-through: every beat produces a result, one cycle of latency.
- Latency: M_AXIS_OUT_tvalid rises on the edge that accepts the last beat, so the word is visible the cycle after that beat.
- Output handshake:
  - M_AXIS_OUT_tvalid stays high, with tdata stable, until a cycle with M_AXIS_OUT_tready=1.
  - Transfer with no new result that cycle: tvalid goes 0.
- Simultaneous events:
  - New result + (tvalid && tready): new result loaded, tvalid stays 1, no overrun.
  - New result + (tvalid && !tready): old word overwritten with the new result, tvalid stays 1, overrun_count += 1 (saturating).
  - New result + tvalid=0: loaded, tvalid=1.
- en has no effect on the output register. A pending word remains valid after en drops.
- Beats with tvalid=0 in ACCUM: no change to acc or cnt.

Test Plan:
- dec_log2=2, en=1, continuous tvalid, samples 4, 8, 12, 16 -> exactly one output word 0x0000000A (10), tvalid high the cycle after the 4th beat; busy low after the 4th beat.
- dec_log2=1, samples -3, -4 (tdata[13:0]=0x3FFD, 0x3FFC) -> output 0xFFFFFFFC (-4, from -7 >>> 1).
- dec_log2=10, 1024 beats of 8191 -> output 0x00001FFF. Then 1024 beats of -8192 -> output 0xFFFFE000. No wrap in either block.
- dec_log2=0, M_AXIS_OUT_tready=0, samples 5, 6, 7 -> tdata ends at 7, tvalid=1, overrun_count=2. Raise tready for one cycle -> word accepted, tvalid=0.
- dec_log2=2; switch dec_log2 to 3 after the 2nd beat; feed 1, 1, 1, 1, then 8 beats of 2 -> outputs 1 then 2, showing the change applied at the block boundary. dec_log2=15 -> blocks of 1024 (clamp).
- Mid-block disturbances, each followed by a full block with dec_log2=2 of 3, 3, 3, 3 -> only 0x00000003 is produced, never a mixed average:
  - en low after 3 of 4 beats, then en high.
  - rst=0 asserted between clock edges after 3 beats -> all outputs 0 immediately, before the next clk edge.
